// File: rtl/vga_timing_pattern_gen.sv
// VGA raster timing generator with a runtime-selectable test-pattern engine.
// All outputs are registered together from one counter state, so sync, de and RGB never skew.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 80,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 21,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COLOR_W    = 4,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [10:0]            x,
    output logic [10:0]            y,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     vgared,
    output logic [COLOR_W-1:0]     vgagreen,
    output logic [COLOR_W-1:0]     vgablue,
    output logic [15:0]            frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_LAST   = 11'(BAR_W - 1);
    localparam logic        HS_ON      = (HS_POL != 0);
    localparam logic        VS_ON      = (VS_POL != 0);

    logic [10:0]          h_cnt, v_cnt;
    logic [10:0]          bar_px;
    logic [2:0]           bar_idx;
    logic [1:0]           mode_sh;
    logic [3*COLOR_W-1:0] solid_sh;
    logic                 first_seen;

    logic                 h_wrap, v_wrap;
    logic                 de_p0, hs_p0, vs_p0, fs_p0;
    logic [3*COLOR_W-1:0] rgb_p0;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign de_p0  = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_p0  = (h_cnt >= HS_START && h_cnt < HS_END) ? HS_ON : ~HS_ON;
    assign vs_p0  = (v_cnt >= VS_START && v_cnt < VS_END) ? VS_ON : ~VS_ON;
    assign fs_p0  = (h_cnt == 11'd0) && (v_cnt == 11'd0);

    always_comb begin
        rgb_p0 = '0;
        if (de_p0) begin
            case (mode_sh)
                2'd0: rgb_p0 = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
                2'd1: rgb_p0 = solid_sh;
                2'd2: rgb_p0 = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? '1 : '0;
                default: rgb_p0 = (h_cnt == 11'd0 || h_cnt == H_ACT_LAST ||
                                   v_cnt == 11'd0 || v_cnt == V_ACT_LAST) ? '1 : '0;
            endcase
        end
    end

    // Stage p0: raster counters, bar tracker and frame-boundary shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            bar_px   <= '0;
            bar_idx  <= '0;
            mode_sh  <= '0;
            solid_sh <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt   <= '0;
                v_cnt   <= v_wrap ? 11'd0 : v_cnt + 11'd1;
                bar_px  <= '0;
                bar_idx <= '0;
            end else begin
                h_cnt <= h_cnt + 11'd1;
                // Bar index saturates at 7 so any remainder pixels stay in the last bar
                if (bar_px == BAR_LAST) begin
                    bar_px <= '0;
                    if (bar_idx != 3'd7)
                        bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 11'd1;
                end
            end
            if (h_wrap && v_wrap) begin
                mode_sh  <= mode;
                solid_sh <= solid_rgb;
            end
        end
    end

    // Stage p1: registered outputs, all derived from the same counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vgared      <= '0;
            vgagreen    <= '0;
            vgablue     <= '0;
            frame_cnt   <= '0;
            first_seen  <= 1'b0;
        end else begin
            hsync       <= hs_p0;
            vsync       <= vs_p0;
            de          <= de_p0;
            x           <= de_p0 ? h_cnt : 11'd0;
            y           <= de_p0 ? v_cnt : 11'd0;
            line_start  <= de_p0 && (h_cnt == 11'd0);
            frame_start <= fs_p0;
            {vgared, vgagreen, vgablue} <= rgb_p0;
            // The first frame after reset is not a completed frame
            if (fs_p0) begin
                first_seen <= 1'b1;
                if (first_seen)
                    frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Directed bench: full-size timing on the default block, patterns and frame behaviour on
// a medium raster, polarity/frame counting/async reset on the reduced raster.
module tb_vga_timing_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Default-parameter instance
    logic        rst_n_d;
    logic [1:0]  mode_d;
    logic [11:0] solid_d;
    logic        hsync_d, vsync_d, de_d, ls_d, fs_d;
    logic [10:0] x_d, y_d;
    logic [3:0]  r_d, g_d, b_d;
    logic [15:0] fc_d;
    logic [11:0] rgb_d;
    assign rgb_d = {r_d, g_d, b_d};

    vga_timing_pattern_gen u_dut_d (
        .clk(clk), .rst_n(rst_n_d), .mode(mode_d), .solid_rgb(solid_d),
        .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .x(x_d), .y(y_d),
        .line_start(ls_d), .frame_start(fs_d),
        .vgared(r_d), .vgagreen(g_d), .vgablue(b_d), .frame_cnt(fc_d)
    );

    // Medium raster: 72 x 44, vsync on lines 41..42
    logic        rst_n_m;
    logic [1:0]  mode_m;
    logic [11:0] solid_m;
    logic        hsync_m, vsync_m, de_m, ls_m, fs_m;
    logic [10:0] x_m, y_m;
    logic [3:0]  r_m, g_m, b_m;
    logic [15:0] fc_m;
    logic [11:0] rgb_m;
    assign rgb_m = {r_m, g_m, b_m};

    vga_timing_pattern_gen #(
        .H_ACTIVE(64), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1), .CHECK_LOG2(5)
    ) u_dut_m (
        .clk(clk), .rst_n(rst_n_m), .mode(mode_m), .solid_rgb(solid_m),
        .hsync(hsync_m), .vsync(vsync_m), .de(de_m), .x(x_m), .y(y_m),
        .line_start(ls_m), .frame_start(fs_m),
        .vgared(r_m), .vgagreen(g_m), .vgablue(b_m), .frame_cnt(fc_m)
    );

    // Reduced raster: 12 x 7, active-high hsync
    logic        rst_n_r;
    logic [1:0]  mode_r;
    logic [11:0] solid_r;
    logic        hsync_r, vsync_r, de_r, ls_r, fs_r;
    logic [10:0] x_r, y_r;
    logic [3:0]  r_r, g_r, b_r;
    logic [15:0] fc_r;
    logic [11:0] rgb_r;
    assign rgb_r = {r_r, g_r, b_r};

    vga_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1)
    ) u_dut_r (
        .clk(clk), .rst_n(rst_n_r), .mode(mode_r), .solid_rgb(solid_r),
        .hsync(hsync_r), .vsync(vsync_r), .de(de_r), .x(x_r), .y(y_r),
        .line_start(ls_r), .frame_start(fs_r),
        .vgared(r_r), .vgagreen(g_r), .vgablue(b_r), .frame_cnt(fc_r)
    );

    typedef struct {
        int          fr;
        int          px;
        int          py;
        logic [11:0] rgb;
    } probe_t;

    logic [11:0] bar_rgb [8];
    probe_t      probes  [15];

    initial begin
        int hs_low, de_hi, fall0, fall1, hits, fr, vs_low, vs_first, fs_cnt, waited;
        logic prev_hs;
        logic [11:0] hs_mask, de_mask;
        bit done;

        bar_rgb = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
        probes = '{
            '{0,  8,  0, 12'h00F}, '{0, 63,  0, 12'hFFF}, '{0,  0,  5, 12'h000},
            '{1,  0,  0, 12'h000}, '{1, 32,  0, 12'hFFF}, '{1, 32, 32, 12'h000},
            '{1, 31, 32, 12'hFFF}, '{2,  0,  0, 12'hA5C}, '{2, 63, 39, 12'hA5C},
            '{3,  0, 20, 12'hFFF}, '{3, 63, 20, 12'hFFF}, '{3, 32,  0, 12'hFFF},
            '{3, 32, 39, 12'hFFF}, '{3,  1,  1, 12'h000}, '{3, 32, 20, 12'h000}
        };

        rst_n_d = 1'b0; rst_n_m = 1'b0; rst_n_r = 1'b0;
        mode_d = 2'd0; solid_d = 12'h000;
        mode_m = 2'd2; solid_m = 12'h000;
        mode_r = 2'd0; solid_r = 12'h000;
        repeat (3) @(posedge clk);
        #1;

        chk("d_rst_hsync", 32'(hsync_d), 32'd1);
        chk("d_rst_vsync", 32'(vsync_d), 32'd1);
        chk("d_rst_de", 32'(de_d), 32'd0);
        chk("d_rst_rgb", 32'(rgb_d), 32'd0);
        chk("d_rst_fc", 32'(fc_d), 32'd0);

        // Default raster: two full lines
        @(negedge clk);
        rst_n_d = 1'b1;
        hs_low = 0; de_hi = 0; fall0 = -1; fall1 = -1; prev_hs = 1'b1;
        for (int k = 0; k < 2112; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                chk("d_first_fs", 32'(fs_d), 32'd1);
                chk("d_first_de", 32'(de_d), 32'd1);
            end
            if (!hsync_d) hs_low++;
            if (prev_hs && !hsync_d) begin
                if (fall0 < 0) fall0 = k;
                else if (fall1 < 0) fall1 = k;
            end
            prev_hs = hsync_d;
            if (de_d) de_hi++;
            if (k < 800 && (k % 100 == 0 || k % 100 == 99))
                chk($sformatf("d_bar_x%0d", k), 32'(rgb_d), 32'(bar_rgb[k / 100]));
            if (k == 900) begin
                chk("d_blank_rgb", 32'(rgb_d), 32'd0);
                chk("d_blank_x", 32'(x_d), 32'd0);
            end
            if (k == 1056) chk("d_line1_ls", 32'(ls_d), 32'd1);
            if (k == 1057) chk("d_line1_ls_off", 32'(ls_d), 32'd0);
            if (k == 1061) chk("d_line1_y", 32'(y_d), 32'd1);
        end
        chk("d_hs_low_cnt", 32'(hs_low), 32'd160);
        chk("d_hs_fall0", 32'(fall0), 32'd816);
        chk("d_hs_fall1", 32'(fall1), 32'd1872);
        chk("d_de_cnt", 32'(de_hi), 32'd1600);
        rst_n_d = 1'b0;

        // Medium raster: bars, checker, solid (switched mid-frame), border
        @(negedge clk);
        rst_n_m = 1'b1;
        fr = -1; vs_low = 0; vs_first = -1; hits = 0;
        for (int k = 0; k < 4 * 3168 + 4; k++) begin
            @(posedge clk);
            #1;
            if (fs_m) begin
                fr++;
                if (fr == 3) chk("m_frame_cnt", 32'(fc_m), 32'd3);
            end
            if (fr == 0 && !vsync_m) begin
                vs_low++;
                if (vs_first < 0) vs_first = k;
            end
            if (de_m) begin
                for (int i = 0; i < 15; i++) begin
                    if (probes[i].fr == fr && int'(x_m) == probes[i].px && int'(y_m) == probes[i].py) begin
                        chk($sformatf("m_probe%0d", i), 32'(rgb_m), 32'(probes[i].rgb));
                        hits++;
                    end
                end
                if (x_m == 11'd0 && y_m == 11'd20) begin
                    if (fr == 1) begin
                        mode_m = 2'd1;
                        solid_m = 12'hA5C;
                    end else if (fr == 2) begin
                        mode_m = 2'd3;
                    end
                end
            end
        end
        chk("m_probe_hits", 32'(hits), 32'd15);
        chk("m_vs_low_cnt", 32'(vs_low), 32'd144);
        chk("m_vs_first", 32'(vs_first), 32'd2952);
        rst_n_m = 1'b0;

        // Reduced raster: polarity, frame counting, async reset
        @(negedge clk);
        rst_n_r = 1'b1;
        fs_cnt = 0; done = 1'b0; hs_mask = '0; de_mask = '0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                chk("r_first_fs", 32'(fs_r), 32'd1);
                chk("r_first_fc", 32'(fc_r), 32'd0);
            end
            if (k < 12) begin
                hs_mask[k] = hsync_r;
                de_mask[k] = de_r;
            end
            if (k == 1) chk("r_bar1", 32'(rgb_r), 32'h00F);
            if (k == 7) chk("r_bar7", 32'(rgb_r), 32'hFFF);
            if (fs_r) begin
                fs_cnt++;
                if (fs_cnt == 2) chk("r_fc_after2", 32'(fc_r), 32'd1);
                if (fs_cnt == 3) begin
                    chk("r_fc_after3", 32'(fc_r), 32'd2);
                    done = 1'b1;
                end
            end
        end
        chk("r_fs_seen", 32'(fs_cnt), 32'd3);
        chk("r_hs_mask", 32'(hs_mask), 32'h600);
        chk("r_de_mask", 32'(de_mask), 32'h0FF);

        waited = 0;
        while (!(de_r && x_r == 11'd7) && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("r_pre_rst_rgb", 32'(rgb_r), 32'hFFF);
        #2;
        rst_n_r = 1'b0;
        #1;
        chk("r_async_de", 32'(de_r), 32'd0);
        chk("r_async_rgb", 32'(rgb_r), 32'd0);
        chk("r_async_hsync", 32'(hsync_r), 32'd0);
        chk("r_async_vsync", 32'(vsync_r), 32'd1);
        chk("r_async_fc", 32'(fc_r), 32'd0);
        chk("r_async_x", 32'(x_r), 32'd0);
        @(negedge clk);
        rst_n_r = 1'b1;
        @(posedge clk);
        #1;
        chk("r_rerelease_fs", 32'(fs_r), 32'd1);
        chk("r_rerelease_fc", 32'(fc_r), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
